// File: rtl/ibuf_bank_ram.sv
`default_nettype none
// ============================================================================
// Module      : ibuf_bank_ram
// Description : One bank of a banked input buffer. Simple dual-port RAM
//               (one write port, one read port) with an optional registered
//               read output. A one-cycle forwarding stage passes the read
//               command on to the next bank in the systolic chain. Wide
//               memory-side writes are steered to this bank by a bank-id
//               field held in the low bits of the write address.
// Revision    : 1.0 - initial release
// ============================================================================
module ibuf_bank_ram #(
   parameter int ADDR_WIDTH = 10,
   parameter int DATA_WIDTH = 32,
   parameter int OUTPUT_REG = 1,
   parameter int BUF_ID_W   = 2,
   parameter int BUF_ID     = 0
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           mem_write_req,
   input  logic [ADDR_WIDTH+BUF_ID_W-1:0] mem_write_addr,
   input  logic [DATA_WIDTH-1:0]          mem_write_data,
   input  logic                           buf_read_req,
   input  logic [ADDR_WIDTH-1:0]          buf_read_addr,
   output logic [DATA_WIDTH-1:0]          buf_read_data,
   output logic                           buf_read_req_fwd,
   output logic [ADDR_WIDTH-1:0]          buf_read_addr_fwd
);

   localparam int DEPTH = 2 ** ADDR_WIDTH;

   // Storage is deliberately not reset so it can map onto block RAM.
   logic [DATA_WIDTH-1:0] mem [DEPTH];

   logic                  write_hit;
   logic [ADDR_WIDTH-1:0] write_word;
   logic [DATA_WIDTH-1:0] rd_reg;

   // Bank-id decode: with no id field every write belongs to this bank.
   generate
      if (BUF_ID_W == 0) begin : g_no_bank_id
         assign write_hit  = 1'b1;
         assign write_word = mem_write_addr[ADDR_WIDTH-1:0];
      end else begin : g_bank_id
         localparam logic [BUF_ID_W-1:0] MY_ID = BUF_ID_W'(BUF_ID);
         assign write_hit  = (mem_write_addr[BUF_ID_W-1:0] == MY_ID);
         assign write_word = mem_write_addr[ADDR_WIDTH+BUF_ID_W-1:BUF_ID_W];
      end
   endgenerate

   // Write port: store the word when the strobe targets this bank.
   always_ff @(posedge clk) begin
      if (mem_write_req && write_hit) begin
         mem[write_word] <= mem_write_data;
      end
   end

   // Read port: capture on request, hold otherwise. A write to the same
   // word on the same edge is not seen here, giving read-first behaviour.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rd_reg <= '0;
      end else if (buf_read_req) begin
         rd_reg <= mem[buf_read_addr];
      end
   end

   // Optional output register adds one cycle of read latency.
   generate
      if (OUTPUT_REG != 0) begin : g_out_reg
         logic [DATA_WIDTH-1:0] out_reg;

         // Retime read data every cycle so it tracks the held read value.
         always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
               out_reg <= '0;
            end else begin
               out_reg <= rd_reg;
            end
         end

         assign buf_read_data = out_reg;
      end else begin : g_no_out_reg
         assign buf_read_data = rd_reg;
      end
   endgenerate

   // Forward the read command unconditionally to skew the next bank by one cycle.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         buf_read_req_fwd  <= 1'b0;
         buf_read_addr_fwd <= '0;
      end else begin
         buf_read_req_fwd  <= buf_read_req;
         buf_read_addr_fwd <= buf_read_addr;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_ibuf_bank_ram.sv
`default_nettype none
// ============================================================================
// Module      : tb_ibuf_bank_ram
// Description : Self-checking bench for ibuf_bank_ram. Two banks with
//               BUF_ID=2 share all inputs: one with the output register and
//               one without. Directed scenarios are followed by a random
//               phase checked against a word-array reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ibuf_bank_ram;

   logic        clk;
   logic        reset;
   logic        mem_write_req;
   logic [11:0] mem_write_addr;
   logic [31:0] mem_write_data;
   logic        buf_read_req;
   logic [9:0]  buf_read_addr;

   logic [31:0] data_r, data_c;
   logic        fwd_req_r, fwd_req_c;
   logic [9:0]  fwd_addr_r, fwd_addr_c;

   int checks = 0;
   int errors = 0;

   // Reference model: word array with written-flags, the value most
   // recently read, and what the registered output should show now.
   logic [31:0] mem_m   [0:1023];
   bit          valid_m [0:1023];
   logic [31:0] last_read_m;
   logic [31:0] delayed_m;
   logic        fwd_req_m;
   logic [9:0]  fwd_addr_m;

   ibuf_bank_ram #(.ADDR_WIDTH(10), .DATA_WIDTH(32), .OUTPUT_REG(1),
                   .BUF_ID_W(2), .BUF_ID(2)) dut_reg (
      .clk               (clk),
      .reset             (reset),
      .mem_write_req     (mem_write_req),
      .mem_write_addr    (mem_write_addr),
      .mem_write_data    (mem_write_data),
      .buf_read_req      (buf_read_req),
      .buf_read_addr     (buf_read_addr),
      .buf_read_data     (data_r),
      .buf_read_req_fwd  (fwd_req_r),
      .buf_read_addr_fwd (fwd_addr_r)
   );

   ibuf_bank_ram #(.ADDR_WIDTH(10), .DATA_WIDTH(32), .OUTPUT_REG(0),
                   .BUF_ID_W(2), .BUF_ID(2)) dut_comb (
      .clk               (clk),
      .reset             (reset),
      .mem_write_req     (mem_write_req),
      .mem_write_addr    (mem_write_addr),
      .mem_write_data    (mem_write_data),
      .buf_read_req      (buf_read_req),
      .buf_read_addr     (buf_read_addr),
      .buf_read_data     (data_c),
      .buf_read_req_fwd  (fwd_req_c),
      .buf_read_addr_fwd (fwd_addr_c)
   );

   // Free-running clock, 10 time units per period.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string tag);
      check({tag, "/data_reg"},  data_r, delayed_m);
      check({tag, "/data_comb"}, data_c, last_read_m);
      check({tag, "/fwd_req_reg"},  {31'd0, fwd_req_r},  {31'd0, fwd_req_m});
      check({tag, "/fwd_req_comb"}, {31'd0, fwd_req_c},  {31'd0, fwd_req_m});
      check({tag, "/fwd_addr_reg"},  {22'd0, fwd_addr_r}, {22'd0, fwd_addr_m});
      check({tag, "/fwd_addr_comb"}, {22'd0, fwd_addr_c}, {22'd0, fwd_addr_m});
   endtask

   task automatic model_clear();
      last_read_m = '0;
      delayed_m   = '0;
      fwd_req_m   = 1'b0;
      fwd_addr_m  = '0;
   endtask

   // Advance the model by one edge using the inputs now applied, then
   // let the DUT take the edge and settle.
   task automatic tick();
      logic [31:0] read_val;
      if (reset) begin
         read_val = last_read_m;
         if (buf_read_req) read_val = mem_m[buf_read_addr];   // old contents
         delayed_m   = last_read_m;
         last_read_m = read_val;
         fwd_req_m   = buf_read_req;
         fwd_addr_m  = buf_read_addr;
         if (mem_write_req && mem_write_addr[1:0] == 2'd2) begin
            mem_m[mem_write_addr[11:2]]   = mem_write_data;
            valid_m[mem_write_addr[11:2]] = 1'b1;
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      mem_write_req = 1'b0;
      buf_read_req  = 1'b0;
   endtask

   task automatic write_word(input logic [9:0] word, input logic [1:0] id, input logic [31:0] data);
      mem_write_req  = 1'b1;
      mem_write_addr = {word, id};
      mem_write_data = data;
      buf_read_req   = 1'b0;
      tick();
      mem_write_req  = 1'b0;
   endtask

   initial begin
      reset          = 1'b0;
      mem_write_req  = 1'b0;
      mem_write_addr = '0;
      mem_write_data = '0;
      buf_read_req   = 1'b1;
      buf_read_addr  = 10'h3FF;
      for (int i = 0; i < 1024; i++) valid_m[i] = 1'b0;
      model_clear();

      // Reset held with a read request pending: everything stays zero.
      repeat (3) @(posedge clk);
      #1;
      check("t1_rst_data_reg",  data_r, 32'd0);
      check("t1_rst_data_comb", data_c, 32'd0);
      check("t1_rst_fwd_req",   {31'd0, fwd_req_r}, 32'd0);
      check("t1_rst_fwd_addr",  {22'd0, fwd_addr_c}, 32'd0);
      reset        = 1'b1;
      buf_read_req = 1'b0;
      tick();
      check_all("t1_release");
      tick();
      check("t1_hold_data_reg", data_r, 32'd0);

      // Basic write then read, both latencies.
      write_word(10'd5, 2'd2, 32'hDEADBEEF);
      buf_read_req  = 1'b1;
      buf_read_addr = 10'd5;
      tick();
      check("t2_comb_t1", data_c, 32'hDEADBEEF);
      check_all("t2_a");
      idle();
      tick();
      check("t2_reg_t2", data_r, 32'hDEADBEEF);
      check_all("t2_b");

      // Writes tagged for another bank are ignored.
      write_word(10'd7, 2'd2, 32'h0);
      write_word(10'd7, 2'd1, 32'h1234);
      buf_read_req  = 1'b1;
      buf_read_addr = 10'd7;
      tick();
      idle();
      tick();
      check("t3_filter_reg",  data_r, 32'h0);
      check("t3_filter_comb", data_c, 32'h0);
      check_all("t3");

      // Forwarding of a single-cycle pulse.
      buf_read_req  = 1'b1;
      buf_read_addr = 10'h3FF;
      tick();
      check("t4_fwd_req_hi",  {31'd0, fwd_req_r}, 32'd1);
      check("t4_fwd_addr_hi", {22'd0, fwd_addr_r}, 32'h3FF);
      buf_read_req  = 1'b0;
      buf_read_addr = 10'd0;
      tick();
      check("t4_fwd_req_lo",  {31'd0, fwd_req_c}, 32'd0);
      check("t4_fwd_addr_lo", {22'd0, fwd_addr_c}, 32'd0);
      check_all("t4");

      // Streaming reads, one per cycle.
      for (int i = 0; i < 16; i++) write_word(10'(i), 2'd2, 32'(i * 3));
      for (int i = 0; i < 16; i++) begin
         buf_read_req  = 1'b1;
         buf_read_addr = 10'(i);
         tick();
         check("t5_stream_comb", data_c, 32'(i * 3));
         if (i > 0) check("t5_stream_reg", data_r, 32'((i - 1) * 3));
         check_all("t5_stream");
      end
      idle();
      tick();
      check("t5_hold_comb", data_c, 32'd45);
      check("t5_hold_reg",  data_r, 32'd45);
      tick();
      check("t5_hold2_reg", data_r, 32'd45);
      check_all("t5_hold");

      // Read-first on same-word collision.
      write_word(10'd9, 2'd2, 32'h1111);
      mem_write_req  = 1'b1;
      mem_write_addr = {10'd9, 2'd2};
      mem_write_data = 32'hA5A5;
      buf_read_req   = 1'b1;
      buf_read_addr  = 10'd9;
      tick();
      check("t6_old", data_c, 32'h1111);
      mem_write_req = 1'b0;
      tick();
      check("t6_new", data_c, 32'hA5A5);
      check_all("t6");
      idle();

      // Reset in the middle of a read discards it immediately.
      buf_read_req  = 1'b1;
      buf_read_addr = 10'd5;
      tick();
      idle();
      #2 reset = 1'b0;
      #1;
      model_clear();
      check("rst_mid_comb", data_c, 32'd0);
      check("rst_mid_reg",  data_r, 32'd0);
      check_all("rst_mid");
      @(posedge clk);
      #1 reset = 1'b1;
      tick();
      check_all("rst_mid_release");

      // Random traffic against the model.
      for (int n = 0; n < 400; n++) begin
         logic [9:0] rw;
         mem_write_req  = ($urandom_range(0, 1) == 1);
         mem_write_addr = {10'($urandom_range(0, 31)), 2'($urandom_range(0, 3))};
         mem_write_data = $urandom;
         rw             = 10'($urandom_range(0, 31));
         buf_read_addr  = rw;
         buf_read_req   = valid_m[rw] && ($urandom_range(0, 3) != 0);
         tick();
         check_all("rand");
      end
      idle();
      tick();
      check_all("final");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
